// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    function automatic logic is_div(op_e op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    function automatic logic is_signed_a(op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic is_signed_b(op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (RV32M) with valid/ready handshakes and flush.
// Operands are converted to magnitudes at accept, the core iterates on unsigned values
// for DATA_WIDTH cycles, and signs are reapplied in a single fix-up cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    localparam logic [W-1:0] MostNeg = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] AllOnes = {W{1'b1}};

    // State and datapath registers
    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [W:0]      hi_q, hi_d;      // product high half / partial remainder
    logic [W-1:0]    lo_q, lo_d;      // multiplier -> product low half / dividend -> quotient
    logic [W-1:0]    b_q, b_d;        // multiplicand / divisor magnitude
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;
    logic            out_valid_q, out_valid_d;

    // Input decode
    op_e          op_in;
    logic         in_neg_a, in_neg_b;
    logic [W-1:0] a_mag, b_mag;
    logic         div_by_zero, div_ovf;

    assign op_in       = op_e'(Operation[2:0]);
    assign in_neg_a    = is_signed_a(op_in) & SrcA[W-1];
    assign in_neg_b    = is_signed_b(op_in) & SrcB[W-1];
    assign a_mag       = in_neg_a ? -SrcA : SrcA;
    assign b_mag       = in_neg_b ? -SrcB : SrcB;
    assign div_by_zero = is_div(op_in) && (SrcB == '0);
    // Only the signed divide/remainder ops can overflow
    assign div_ovf     = (op_in inside {OpDiv, OpRem}) && (SrcA == MostNeg) && (SrcB == AllOnes);

    // One iteration of shift-add multiply
    logic [W:0] mul_sum;
    assign mul_sum = hi_q + {1'b0, (lo_q[0] ? b_q : {W{1'b0}})};

    // One iteration of restoring divide; diff[W] set means the trial subtraction borrowed
    logic [W:0] div_shift, div_diff;
    logic       div_ge;
    assign div_shift = {hi_q[W-1:0], lo_q[W-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_diff[W];

    // Sign fix-up of the finished iteration
    logic [2*W-1:0] prod_raw, prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, fix_result;
    assign prod_raw = {hi_q[W-1:0], lo_q};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_raw : prod_raw;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    assign rem_fix  = neg_a_q ? -hi_q[W-1:0] : hi_q[W-1:0];

    // Output selection by operation
    always_comb begin
        fix_result = '0;
        unique case (op_q)
            OpMul:                       fix_result = prod_fix[W-1:0];
            OpMulh, OpMulhsu, OpMulhu:   fix_result = prod_fix[2*W-1:W];
            OpDiv, OpDivu:               fix_result = quot_fix;
            OpRem, OpRemu:               fix_result = rem_fix;
            default:                     fix_result = '0;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    op_d    = op_in;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    hi_d    = '0;
                    lo_d    = a_mag;
                    b_d     = b_mag;
                    cnt_d   = CntW'(W - 1);
                    if (div_by_zero) begin
                        // REM/REMU return the dividend, DIV/DIVU return all ones
                        result_d    = op_in[1] ? SrcA : AllOnes;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else if (div_ovf) begin
                        result_d    = op_in[1] ? {W{1'b0}} : MostNeg;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (is_div(op_q)) begin
                    hi_d = div_ge ? div_diff : div_shift;
                    lo_d = {lo_q[W-2:0], div_ge};
                end else begin
                    hi_d = {1'b0, mul_sum[W:1]};
                    lo_d = {mul_sum[0], lo_q[W-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d    = fix_result;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over accept and over the output handshake
        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OpMul;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign Result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes reference results at accept, a
// negedge monitor pops and compares whenever the unit hands a result over.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    Operation;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Result;

    always #5 clk = ~clk;

    muldiv_unit #(
        .DATA_WIDTH    (W),
        .OPCODE_LENGTH (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result)
    );

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           acc;
        logic [2:0]   op;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rand_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the RV32M arithmetic rules
    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [63:0] sa, sbx, ua, ub, p;
        longint      qa, qb;
        sa  = {{32{a[31]}}, a};
        sbx = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        qa  = longint'(sa);
        qb  = longint'(sbx);
        case (op)
            3'd0: begin p = sa * sbx; return p[31:0]; end
            3'd1: begin p = sa * sbx; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(qa / qb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(qa % qb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 2;
    endfunction

    // Present a request and hold it until accepted; returns at posedge+1
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 0;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready && !flush && !reset) begin
                e.res = ref_model(op, a, b);
                e.lat = exp_latency(op, a, b);
                e.acc = cyc + 1;
                e.op  = op;
                sb.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid  = 1'b0;
        SrcA      = $urandom;
        SrcB      = $urandom;
        Operation = 3'($urandom_range(0, 7));
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares results, latency, hold-under-backpressure and post-handshake state
    bit           seen = 0;
    bit           hold_prev = 0;
    bit           hs_prev = 0;
    bit           flush_prev = 0;
    logic [W-1:0] res_prev = '0;

    always @(negedge clk) begin
        if (reset) begin
            seen      = 0;
            hold_prev = 0;
            hs_prev   = 0;
        end else begin
            if (hold_prev && !flush_prev) begin
                chk("hold_out_valid", 32'(out_valid), 32'd1);
                chk("hold_result", Result, res_prev);
            end
            if (hs_prev && !flush_prev) begin
                chk("post_handshake_in_ready", 32'(in_ready), 32'd1);
                chk("post_handshake_out_valid", 32'(out_valid), 32'd0);
            end
            if (out_valid) begin
                chk("in_ready_while_valid", 32'(in_ready), 32'd0);
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        chk($sformatf("latency_op%0d", sb[0].op), 32'(cyc + 1 - sb[0].acc),
                            32'(sb[0].lat));
                    end
                    if (out_ready) begin
                        chk($sformatf("result_op%0d", sb[0].op), Result, sb[0].res);
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            hs_prev   = out_valid && out_ready;
        end
        flush_prev = flush;
        res_prev   = Result;
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        Operation = 3'd0;
        SrcA      = '0;
        SrcB      = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", Result, 32'd0);

        // Directed arithmetic cases
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);               wait_drain();
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);       wait_drain();
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);       wait_drain();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);       wait_drain();
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);               wait_drain();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);               wait_drain();
        issue(3'd5, 32'd100, 32'd7);                     wait_drain();
        issue(3'd7, 32'd100, 32'd7);                     wait_drain();
        issue(3'd5, 32'd5, 32'd0);                       wait_drain();
        issue(3'd7, 32'd5, 32'd0);                       wait_drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);       wait_drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);       wait_drain();

        // Backpressure: result held for several cycles with out_ready low
        out_ready = 1'b0;
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int n = 0; n < 60 && !out_valid; n++) @(negedge clk);
        chk("bp_reached_valid", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Flush in CALC with a would-be-immediate request also present
        issue(3'd0, 32'd123, 32'd456);
        repeat (9) @(posedge clk);
        #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        Operation = 3'd5;
        SrcA      = 32'd5;
        SrcB      = 32'd0;
        sb.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_calc_in_ready", 32'(in_ready), 32'd1);
        chk("flush_calc_out_valid", 32'(out_valid), 32'd0);
        repeat (45) @(negedge clk);

        // Flush in IDLE beats a same-cycle accept
        @(posedge clk);
        #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        Operation = 3'd7;
        SrcA      = 32'd9;
        SrcB      = 32'd0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
        chk("flush_idle_out_valid", 32'(out_valid), 32'd0);
        repeat (5) @(negedge clk);

        // Reset mid-CALC
        issue(3'd4, 32'hDEAD_BEEF, 32'd17);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_calc_in_ready", 32'(in_ready), 32'd1);
        chk("reset_calc_out_valid", 32'(out_valid), 32'd0);
        chk("reset_calc_result", Result, 32'd0);
        repeat (45) @(negedge clk);

        // Random regression with random out_ready
        rand_ready = 1;
        for (int i = 0; i < 1200; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end
        @(posedge clk);
        #2;
        rand_ready = 0;
        out_ready  = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
